oam_dma: RTL and testbench



---
 rtl/oam_dma_if.sv | 24 ++
 rtl/oam_dma.sv | 118 +++++++++++
 tb/tb_oam_dma.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/oam_dma_if.sv
// CPU-side and system-bus-side signals of the sprite DMA engine.
// The slave modport is the DMA block; the master modport is the CPU/bus environment.
interface oam_dma_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_rw;
    logic        cpu_ready;
    logic [15:0] bus_addr;
    logic [7:0]  bus_dout;
    logic [7:0]  bus_din;
    logic        bus_rw;
    logic        dma_busy;
    logic        cycle_odd;

    modport slave (
        input  cpu_addr, cpu_dout, cpu_rw, bus_din,
        output cpu_ready, bus_addr, bus_dout, bus_rw, dma_busy, cycle_odd
    );

    modport master (
        output cpu_addr, cpu_dout, cpu_rw, bus_din,
        input  cpu_ready, bus_addr, bus_dout, bus_rw, dma_busy, cycle_odd
    );
endinterface

// File: rtl/oam_dma.sv
// Sprite DMA: snoops CPU writes to DMA_REG, stalls the CPU and copies one
// 256-byte page to the OAM data port as alternating read/write bus cycles.
module oam_dma #(
    parameter logic [15:0] DMA_REG  = 16'h4014,
    parameter logic [15:0] OAM_ADDR = 16'h2004
) (
    input  logic          clk,
    input  logic          n_reset,
    oam_dma_if.slave      io
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ALIGN,
        S_READ,
        S_WRITE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  data_q, data_d;
    logic        odd_q;

    logic        cpu_ready_d;
    logic        dma_busy_d;
    logic [15:0] bus_addr_d;
    logic [7:0]  bus_dout_d;
    logic        bus_rw_d;
    logic        trigger;

    assign trigger = !io.cpu_rw && (io.cpu_addr == DMA_REG);

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q <= S_IDLE;
            page_q  <= 8'h00;
            cnt_q   <= 8'h00;
            data_q  <= 8'h00;
            odd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            odd_q   <= ~odd_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        page_d      = page_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        cpu_ready_d = 1'b0;
        dma_busy_d  = 1'b0;
        bus_addr_d  = io.cpu_addr;
        bus_dout_d  = io.cpu_dout;
        bus_rw_d    = io.cpu_rw;

        case (state_q)
            S_IDLE: begin
                cpu_ready_d = 1'b1;
                if (trigger) begin
                    page_d  = io.cpu_dout;
                    cnt_d   = 8'h00;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (trigger) begin
                    page_d = io.cpu_dout;
                    cnt_d  = 8'h00;
                end
                // The first CPU read cycle is the halt cycle; reads must land on even cycles.
                if (io.cpu_rw) begin
                    dma_busy_d = 1'b1;
                    state_d    = odd_q ? S_READ : S_ALIGN;
                end
            end
            S_ALIGN: begin
                dma_busy_d = 1'b1;
                bus_rw_d   = 1'b1;
                state_d    = S_READ;
            end
            S_READ: begin
                dma_busy_d = 1'b1;
                bus_addr_d = {page_q, cnt_q};
                bus_rw_d   = 1'b1;
                data_d     = io.bus_din;
                state_d    = S_WRITE;
            end
            S_WRITE: begin
                dma_busy_d = 1'b1;
                bus_addr_d = OAM_ADDR;
                bus_rw_d   = 1'b0;
                bus_dout_d = data_q;
                if (cnt_q == 8'hFF) begin
                    cnt_d   = 8'h00;
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                    state_d = S_READ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign io.cpu_ready = cpu_ready_d;
    assign io.dma_busy  = dma_busy_d;
    assign io.bus_addr  = bus_addr_d;
    assign io.bus_dout  = bus_dout_d;
    assign io.bus_rw    = bus_rw_d;
    assign io.cycle_odd = odd_q;
endmodule

// File: tb/tb_oam_dma.sv
// Directed/randomized bench for oam_dma: a scripted CPU plus a byte-array memory,
// with whole-transfer expectations derived from the page contents and halt parity.
module tb_oam_dma;
    logic clk = 1'b0;
    logic n_reset = 1'b0;

    oam_dma_if io();

    oam_dma #(.DMA_REG(16'h4014), .OAM_ADDR(16'h2004)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .io      (io.slave)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:65535];
    assign io.bus_din = mem[io.bus_addr];

    int checks = 0;
    int failures = 0;

    // Independent parity reference: toggles every edge, cleared by reset.
    logic exp_odd = 1'b0;
    always @(posedge clk) exp_odd <= n_reset ? ~exp_odd : 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic rw, input logic [7:0] d);
        io.cpu_addr = a;
        io.cpu_rw   = rw;
        io.cpu_dout = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Trigger so that the halt cycle (first CPU read after nwr writes) has parity halt_odd.
    task automatic start_transfer(input logic [7:0] page, input bit halt_odd, input int nwr,
                                  input logic [15:0] r_addr);
        bit want;
        int pass_bad;
        want = halt_odd ^ bit'((nwr + 1) & 1);
        if (exp_odd != want) begin
            drive(r_addr, 1'b1, 8'h00);
            next_cycle();
        end
        drive(16'h4014, 1'b0, page);
        @(negedge clk);
        check("trig_ready", io.cpu_ready, 1);
        next_cycle();
        pass_bad = 0;
        for (int j = 0; j < nwr; j++) begin
            drive(16'h00FF - 16'(j), 1'b0, 8'($urandom));
            @(negedge clk);
            if (io.bus_addr !== io.cpu_addr || io.bus_rw !== 1'b0 || io.bus_dout !== io.cpu_dout ||
                io.cpu_ready !== 1'b0 || io.dma_busy !== 1'b0)
                pass_bad++;
            next_cycle();
        end
        if (nwr > 0) check("wait_write_pass", pass_bad, 0);
        drive(r_addr, 1'b1, 8'h00);
    endtask

    task automatic run_transfer(input string name, input logic [7:0] page, input bit halt_odd,
                                input int nwr);
        logic [15:0] r_addr;
        logic [7:0]  wq[$];
        logic [15:0] rq[$];
        int low, pthru, oddread, busy_bad, parity_bad, other, data_bad, addr_bad;
        bit done, first;
        r_addr = {page ^ 8'h80, 8'h34};
        start_transfer(page, halt_odd, nwr, r_addr);
        low = 0; pthru = 0; oddread = 0; busy_bad = 0; parity_bad = 0; other = 0;
        done = 0; first = 1;
        for (int c = 0; c < 1200 && !done; c++) begin
            @(negedge clk);
            if (first) begin
                check("halt_parity", io.cycle_odd, 32'(halt_odd));
                check("halt_busy", io.dma_busy, 1);
                first = 0;
            end
            if (io.cycle_odd !== exp_odd) parity_bad++;
            if (io.cpu_ready === 1'b1) begin
                done = 1;
                check("end_addr_pass", io.bus_addr, r_addr);
                check("end_rw_pass", io.bus_rw, 1);
                check("end_busy", io.dma_busy, 0);
            end else begin
                low++;
                if (io.dma_busy !== 1'b1) busy_bad++;
                if (io.bus_rw === 1'b0 && io.bus_addr === 16'h2004) wq.push_back(io.bus_dout);
                else if (io.bus_rw === 1'b1 && io.bus_addr === r_addr) pthru++;
                else if (io.bus_rw === 1'b1) begin
                    rq.push_back(io.bus_addr);
                    if (io.cycle_odd !== 1'b0) oddread++;
                end else other++;
            end
            next_cycle();
        end
        check("completed", 32'(done), 1);
        check("ready_low_cycles", low, halt_odd ? 513 : 514);
        check("cpu_addr_reads", pthru, halt_odd ? 1 : 2);
        check("write_count", wq.size(), 256);
        check("read_count", rq.size(), 256);
        data_bad = 0; addr_bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (i < wq.size() && wq[i] !== mem[{page, 8'(i)}]) data_bad++;
            if (i < rq.size() && rq[i] !== {page, 8'(i)}) addr_bad++;
        end
        check("write_data", data_bad, 0);
        check("read_addr", addr_bad, 0);
        check("odd_reads", oddread, 0);
        check("busy_low", busy_bad, 0);
        check("parity_track", parity_bad, 0);
        check("stray_writes", other, 0);
        $display("transfer %s page=%02h halt_odd=%0d cpu_writes=%0d ready_low=%0d dma_writes=%0d",
                 name, page, halt_odd, nwr, low, wq.size());
    endtask

    task automatic run_abort(input logic [7:0] page, input bit halt_odd);
        logic [15:0] r_addr;
        int nw, late_w, late_low;
        bit hit;
        r_addr = {page ^ 8'h80, 8'h34};
        start_transfer(page, halt_odd, 0, r_addr);
        nw = 0; hit = 0;
        for (int c = 0; c < 600 && !hit; c++) begin
            @(negedge clk);
            if (io.bus_rw === 1'b0 && io.bus_addr === 16'h2004 && io.cpu_ready === 1'b0) nw++;
            if (nw == 100) begin
                n_reset = 1'b0;
                hit = 1;
            end
            next_cycle();
        end
        n_reset = 1'b1;
        check("abort_reached", 32'(hit), 1);
        @(negedge clk);
        check("abort_ready", io.cpu_ready, 1);
        check("abort_busy", io.dma_busy, 0);
        check("abort_odd", io.cycle_odd, 0);
        check("abort_addr_pass", io.bus_addr, r_addr);
        check("abort_rw_pass", io.bus_rw, 1);
        next_cycle();
        late_w = 0; late_low = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (io.bus_rw === 1'b0 && io.bus_addr === 16'h2004) late_w++;
            if (io.cpu_ready !== 1'b1) late_low++;
            next_cycle();
        end
        check("abort_no_writes", late_w, 0);
        check("abort_ready_stays", late_low, 0);
        $display("abort page=%02h writes_before_reset=%0d writes_after=%0d", page, nw, late_w);
    endtask

    initial begin
        int low_cnt;
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'hA5;

        drive(16'h8123, 1'b1, 8'h00);
        n_reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", io.cpu_ready, 1);
        check("rst_busy", io.dma_busy, 0);
        check("rst_odd", io.cycle_odd, 0);
        check("rst_addr_pass", io.bus_addr, 16'h8123);
        @(posedge clk);
        #1;
        n_reset = 1'b1;

        // Writes to OAM_ADDR and reads of DMA_REG must not trigger.
        drive(16'h2004, 1'b0, 8'h5C);
        @(negedge clk);
        check("nt_write_addr", io.bus_addr, 16'h2004);
        check("nt_write_data", io.bus_dout, 8'h5C);
        check("nt_write_rw", io.bus_rw, 0);
        next_cycle();
        drive(16'h4014, 1'b1, 8'h02);
        @(negedge clk);
        check("nt_read_rw", io.bus_rw, 1);
        next_cycle();
        low_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            drive(16'(16'h8000 + c), 1'b1, 8'h00);
            @(negedge clk);
            if (io.cpu_ready !== 1'b1 || io.dma_busy !== 1'b0) low_cnt++;
            next_cycle();
        end
        check("nt_ready_stays", low_cnt, 0);
        $display("no-trigger accesses: ready_low_cycles=%0d", low_cnt);

        run_transfer("page02_odd", 8'h02, 1'b1, 0);
        run_transfer("page02_even", 8'h02, 1'b0, 0);
        run_transfer("cpu_writes_first", 8'($urandom_range(0, 255)), 1'($urandom), 2);
        run_transfer("pageFF", 8'hFF, 1'($urandom), 0);
        run_abort(8'($urandom_range(0, 255)), 1'($urandom));
        for (int k = 0; k < 2; k++)
            run_transfer("random", 8'($urandom_range(0, 255)), 1'($urandom), int'($urandom_range(0, 3)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
